// File: rtl/aclk_ctrl_multi_if.sv
// Keypad/button bus between the alarm-clock front end and its control FSM.
// master drives the user inputs; slave is the controller producing strobes.
interface aclk_ctrl_multi_if #(
    parameter int NUM_ALARMS = 2
);
    logic                  one_second;
    logic                  time_button;
    logic                  alarm_button;
    logic [1:0]            alarm_sel;
    logic [3:0]            key;

    logic                  reset_count;
    logic                  load_new_c;
    logic [NUM_ALARMS-1:0] load_new_a;
    logic                  show_a;
    logic [1:0]            show_sel;
    logic                  show_new_time;
    logic                  shift;
    logic [2:0]            digit_count;
    logic                  entry_error;

    modport master (
        output one_second, time_button, alarm_button, alarm_sel, key,
        input  reset_count, load_new_c, load_new_a, show_a, show_sel,
               show_new_time, shift, digit_count, entry_error
    );

    modport slave (
        input  one_second, time_button, alarm_button, alarm_sel, key,
        output reset_count, load_new_c, load_new_a, show_a, show_sel,
               show_new_time, shift, digit_count, entry_error
    );
endinterface

// File: rtl/aclk_ctrl_multi.sv
// Alarm-clock keypad controller: collects key digits, commits them as the
// current time or as one of several alarms, and times out idle entries.
module aclk_ctrl_multi #(
    parameter int NUM_ALARMS  = 2,
    parameter int TIMEOUT_SEC = 10,
    parameter int DIGITS      = 4,
    parameter int NOKEY       = 10
) (
    input  logic             clock,
    input  logic             reset,
    aclk_ctrl_multi_if.slave bus
);

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6,
        ENTRY_ERROR      = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            tmo_q, tmo_d;
    logic [2:0]            digit_q, digit_d;
    logic [1:0]            sel_q, sel_d;

    logic                  shift_q, shift_d;
    logic                  show_new_q, show_new_d;
    logic                  show_a_q, show_a_d;
    logic                  load_c_q, load_c_d;
    logic                  error_q, error_d;
    logic [NUM_ALARMS-1:0] load_a_q, load_a_d;

    logic                  key_idle;
    logic                  tmo_active;
    logic                  timeout;
    logic                  entry_full;
    logic [1:0]            sel_in;

    assign key_idle   = (bus.key == 4'(NOKEY));
    assign tmo_active = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    assign timeout    = tmo_active && bus.one_second && (tmo_q == 4'(TIMEOUT_SEC - 1));
    assign entry_full = (digit_q == 3'(DIGITS));
    // Channels beyond the implemented alarm count fall back to channel 0.
    assign sel_in     = (int'(bus.alarm_sel) < NUM_ALARMS) ? bus.alarm_sel : 2'd0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            SHOW_TIME: begin
                if (bus.alarm_button) begin
                    state_d = SHOW_ALARM;
                    sel_d   = sel_in;
                end else if (!key_idle) begin
                    state_d = KEY_STORED;
                end
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button) state_d = SHOW_TIME;
            end
            KEY_STORED: state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (key_idle)     state_d = KEY_ENTRY;
                else if (timeout) state_d = SHOW_TIME;
            end
            KEY_ENTRY: begin
                // Alarm commit outranks time commit when both buttons arrive together.
                if (bus.alarm_button) begin
                    sel_d   = sel_in;
                    state_d = entry_full ? SET_ALARM_TIME : ENTRY_ERROR;
                end else if (bus.time_button) begin
                    state_d = entry_full ? SET_CURRENT_TIME : ENTRY_ERROR;
                end else if (timeout) begin
                    state_d = SHOW_TIME;
                end else if (!key_idle) begin
                    state_d = KEY_STORED;
                end
            end
            SET_ALARM_TIME, SET_CURRENT_TIME, ENTRY_ERROR: state_d = SHOW_TIME;
            default: state_d = SHOW_TIME;
        endcase
    end

    // Inactivity counter restarts whenever the state changes.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_d != state_q) || !tmo_active) begin
            tmo_d = 4'd0;
        end else if (bus.one_second) begin
            tmo_d = tmo_q + 4'd1;
        end
    end

    always_comb begin
        digit_d = digit_q;
        if (state_d == SHOW_TIME) begin
            digit_d = 3'd0;
        end else if ((state_q == KEY_STORED) && !entry_full) begin
            digit_d = digit_q + 3'd1;
        end
    end

    // Outputs are decoded from the next state and registered, so each one
    // tracks the present state with no combinational path to the pins.
    always_comb begin
        shift_d    = (state_d == KEY_STORED);
        show_new_d = (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                     (state_d == KEY_ENTRY);
        show_a_d   = (state_d == SHOW_ALARM);
        load_c_d   = (state_d == SET_CURRENT_TIME);
        error_d    = (state_d == ENTRY_ERROR);
    end

    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_load_a
            assign load_a_d[gi] = (state_d == SET_ALARM_TIME) && (sel_d == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= SHOW_TIME;
            tmo_q      <= 4'd0;
            digit_q    <= 3'd0;
            sel_q      <= 2'd0;
            shift_q    <= 1'b0;
            show_new_q <= 1'b0;
            show_a_q   <= 1'b0;
            load_c_q   <= 1'b0;
            error_q    <= 1'b0;
            load_a_q   <= '0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            digit_q    <= digit_d;
            sel_q      <= sel_d;
            shift_q    <= shift_d;
            show_new_q <= show_new_d;
            show_a_q   <= show_a_d;
            load_c_q   <= load_c_d;
            error_q    <= error_d;
            load_a_q   <= load_a_d;
        end
    end

    assign bus.shift         = shift_q;
    assign bus.show_new_time = show_new_q;
    assign bus.show_a        = show_a_q;
    assign bus.load_new_c    = load_c_q;
    assign bus.reset_count   = load_c_q;
    assign bus.entry_error   = error_q;
    assign bus.load_new_a    = load_a_q;
    assign bus.show_sel      = sel_q;
    assign bus.digit_count   = digit_q;

endmodule

// File: tb/tb_aclk_ctrl_multi.sv
// Directed bench for aclk_ctrl_multi (2 alarms, 4 digits, 10 s timeout);
// every output is checked as one packed word against hand-computed values.
module tb_aclk_ctrl_multi;

    localparam logic [3:0] NOKEY = 4'd10;

    logic clock;
    logic reset;
    int   tests_run;
    int   fail_count;

    aclk_ctrl_multi_if #(.NUM_ALARMS(2)) bus ();

    aclk_ctrl_multi #(
        .NUM_ALARMS (2),
        .TIMEOUT_SEC(10),
        .DIGITS     (4),
        .NOKEY      (10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed order: reset_count, load_new_c, load_new_a[1:0], show_a,
    // show_sel[1:0], show_new_time, shift, digit_count[2:0], entry_error
    function automatic logic [12:0] o(input bit rc, input bit lc, input bit [1:0] la,
                                      input bit sa, input bit [1:0] ss, input bit snt,
                                      input bit sh, input bit [2:0] dc, input bit ee);
        return {rc, lc, la, sa, ss, snt, sh, dc, ee};
    endfunction

    function automatic logic [12:0] idle(input bit [1:0] ss);
        return o(1'b0, 1'b0, 2'b00, 1'b0, ss, 1'b0, 1'b0, 3'd0, 1'b0);
    endfunction

    function automatic logic [12:0] ent(input bit sh, input bit [2:0] dc, input bit [1:0] ss);
        return o(1'b0, 1'b0, 2'b00, 1'b0, ss, 1'b1, sh, dc, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = {bus.reset_count, bus.load_new_c, bus.load_new_a, bus.show_a,
                    bus.show_sel, bus.show_new_time, bus.shift, bus.digit_count,
                    bus.entry_error};
        tests_run++;
        $display("[TB] %-18s observed=%b expected=%b", tag, observed, expected);
        assert (observed === expected)
        else begin
            fail_count++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Press and release one key starting from SHOW_TIME or KEY_ENTRY.
    task automatic enter_digit(input logic [3:0] k, input bit [2:0] dc_before,
                               input bit [2:0] dc_after, input bit [1:0] ss);
        bus.key = k;
        tick();
        chk("key_stored", ent(1'b1, dc_before, ss));
        bus.key = NOKEY;
        tick();
        chk("key_waited", ent(1'b0, dc_after, ss));
        tick();
        chk("key_entry", ent(1'b0, dc_after, ss));
    endtask

    task automatic pulse();
        bus.one_second = 1'b1;
        tick();
        bus.one_second = 1'b0;
        tick();
    endtask

    initial begin
        tests_run        = 0;
        fail_count       = 0;
        reset            = 1'b1;
        bus.one_second   = 1'b0;
        bus.time_button  = 1'b0;
        bus.alarm_button = 1'b0;
        bus.alarm_sel    = 2'd0;
        bus.key          = NOKEY;

        // Reset takes effect without a clock edge
        #3 reset = 1'b0;
        #1 chk("reset_async", idle(2'd0));
        tick();
        chk("reset_held", idle(2'd0));
        #3 reset = 1'b1;
        tick();
        chk("idle_after_reset", idle(2'd0));

        // Four digits committed as current time
        enter_digit(4'd1, 3'd0, 3'd1, 2'd0);
        enter_digit(4'd2, 3'd1, 3'd2, 2'd0);
        enter_digit(4'd3, 3'd2, 3'd3, 2'd0);
        enter_digit(4'd4, 3'd3, 3'd4, 2'd0);
        bus.time_button = 1'b1;
        tick();
        chk("set_current_time", o(1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 1'b0));
        bus.time_button = 1'b0;
        tick();
        chk("after_set_time", idle(2'd0));

        // Four digits committed as alarm 1
        enter_digit(4'd5, 3'd0, 3'd1, 2'd0);
        enter_digit(4'd6, 3'd1, 3'd2, 2'd0);
        enter_digit(4'd7, 3'd2, 3'd3, 2'd0);
        enter_digit(4'd8, 3'd3, 3'd4, 2'd0);
        bus.alarm_sel    = 2'd1;
        bus.alarm_button = 1'b1;
        tick();
        chk("set_alarm_1", o(1'b0, 1'b0, 2'b10, 1'b0, 2'd1, 1'b0, 1'b0, 3'd4, 1'b0));
        bus.alarm_button = 1'b0;
        bus.alarm_sel    = 2'd0;
        tick();
        chk("after_set_alarm", idle(2'd1));

        // Show alarm with an out-of-range channel, then channel 1
        bus.alarm_sel    = 2'd3;
        bus.alarm_button = 1'b1;
        tick();
        chk("show_alarm_sel3", o(1'b0, 1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0));
        tick();
        chk("show_alarm_hold", o(1'b0, 1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0));
        bus.alarm_button = 1'b0;
        tick();
        chk("show_alarm_exit", idle(2'd0));
        bus.alarm_sel    = 2'd1;
        bus.alarm_button = 1'b1;
        tick();
        chk("show_alarm_sel1", o(1'b0, 1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 3'd0, 1'b0));
        bus.alarm_button = 1'b0;
        tick();
        chk("show_alarm_exit1", idle(2'd1));

        // Incomplete entry is rejected
        enter_digit(4'd9, 3'd0, 3'd1, 2'd1);
        enter_digit(4'd0, 3'd1, 3'd2, 2'd1);
        bus.time_button = 1'b1;
        tick();
        chk("entry_error", o(1'b0, 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 1'b0, 3'd2, 1'b1));
        bus.time_button = 1'b0;
        tick();
        chk("after_error", idle(2'd1));

        // Five keys saturate the count; both buttons together pick the alarm
        enter_digit(4'd1, 3'd0, 3'd1, 2'd1);
        enter_digit(4'd2, 3'd1, 3'd2, 2'd1);
        enter_digit(4'd3, 3'd2, 3'd3, 2'd1);
        enter_digit(4'd4, 3'd3, 3'd4, 2'd1);
        enter_digit(4'd5, 3'd4, 3'd4, 2'd1);
        bus.alarm_sel    = 2'd0;
        bus.alarm_button = 1'b1;
        bus.time_button  = 1'b1;
        tick();
        chk("both_buttons", o(1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 1'b0));
        bus.alarm_button = 1'b0;
        bus.time_button  = 1'b0;
        tick();
        chk("after_both", idle(2'd0));

        // Idle timeout in KEY_ENTRY
        enter_digit(4'd7, 3'd0, 3'd1, 2'd0);
        repeat (9) pulse();
        chk("entry_nine_pulses", ent(1'b0, 3'd1, 2'd0));
        repeat (40) tick();
        chk("entry_no_pulse", ent(1'b0, 3'd1, 2'd0));
        bus.one_second = 1'b1;
        tick();
        bus.one_second = 1'b0;
        chk("entry_tenth_pulse", idle(2'd0));
        tick();
        chk("entry_timeout_idle", idle(2'd0));

        // Key held down times out in KEY_WAITED
        bus.key = 4'd5;
        tick();
        chk("held_stored", ent(1'b1, 3'd0, 2'd0));
        tick();
        chk("held_waited", ent(1'b0, 3'd1, 2'd0));
        repeat (9) pulse();
        chk("held_nine_pulses", ent(1'b0, 3'd1, 2'd0));
        bus.one_second = 1'b1;
        tick();
        bus.one_second = 1'b0;
        bus.key        = NOKEY;
        chk("held_tenth_pulse", idle(2'd0));

        // Reset mid-entry with both buttons high
        bus.key = 4'd3;
        tick();
        tick();
        chk("pre_reset_waited", ent(1'b0, 3'd1, 2'd0));
        bus.alarm_button = 1'b1;
        bus.time_button  = 1'b1;
        #2 reset = 1'b0;
        #1 chk("reset_mid_entry", idle(2'd0));
        tick();
        chk("reset_mid_held", idle(2'd0));
        bus.alarm_button = 1'b0;
        bus.time_button  = 1'b0;
        bus.key          = NOKEY;
        #2 reset = 1'b1;
        tick();
        chk("post_reset", idle(2'd0));
        tick();
        chk("post_reset_quiet", idle(2'd0));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
